reg_wb_seq: RTL and testbench

REG_WB_SEQ -- requirements
Module: reg_wb_seq

---
 rtl/reg_wb_seq_if.sv | 25 ++
 rtl/reg_wb_seq.sv | 105 ++++++++++
 tb/tb_reg_wb_seq.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/reg_wb_seq_if.sv
// reg_wb_seq_if: operand read, ALU/load writeback and dual-port register RAM bus
interface reg_wb_seq_if;
  logic        rd_req;
  logic [5:0]  rd_src1, rd_src2;
  logic        rd_gnt, rd_valid;
  logic [31:0] rd_d1, rd_d2;
  logic        alu_we;
  logic [5:0]  alu_addr;
  logic [31:0] alu_data;
  logic        ld_we;
  logic [5:0]  ld_addr;
  logic [31:0] ld_data;
  logic        ld_full, ld_ovf;
  logic        nwea, clka, nweb, clkb;
  logic [5:0]  aa, ab;
  logic [31:0] da, db, qa, qb;
  modport slave (
    input  rd_req, rd_src1, rd_src2, alu_we, alu_addr, alu_data, ld_we, ld_addr, ld_data, qa, qb,
    output rd_gnt, rd_valid, rd_d1, rd_d2, ld_full, ld_ovf, nwea, clka, aa, da, nweb, clkb, ab, db
  );
  modport master (
    output rd_req, rd_src1, rd_src2, alu_we, alu_addr, alu_data, ld_we, ld_addr, ld_data, qa, qb,
    input  rd_gnt, rd_valid, rd_d1, rd_d2, ld_full, ld_ovf, nwea, clka, aa, da, nweb, clkb, ab, db
  );
endinterface

// File: rtl/reg_wb_seq.sv
// reg_wb_seq: register-file port sequencer with 4-deep load writeback FIFO (REG_WB_SEQ_OVF_EN enables sticky ld_ovf)
module reg_wb_seq (
  input logic         sys_clk,
  input logic         reset,
  reg_wb_seq_if.slave bus
);
  logic [5:0]  fa_q [4], fa_d [4];
  logic [31:0] fd_q [4], fd_d [4];
  logic [3:0]  v_q, v_d;
  logic [1:0]  head_q, head_d, tail_q, tail_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d, full_q, full_d, ovf_q, ovf_d;
  logic [31:0] d1_q, d1_d, d2_q, d2_d;
  logic        full, push, pop, hazard, gnt;
  always_comb begin
    full = cnt_q == 3'd4;
    push = bus.ld_we && !full && !reset;
    hazard = push && (bus.ld_addr == bus.rd_src1 || bus.ld_addr == bus.rd_src2);
    for (int i = 0; i < 4; i++)
      if (v_q[i] && (fa_q[i] == bus.rd_src1 || fa_q[i] == bus.rd_src2)) hazard = 1'b1;
    gnt = 1'b0;
    pop = 1'b0;
    bus.clka = 1'b0;
    bus.nwea = 1'b1;
    bus.aa = bus.alu_addr;
    bus.da = bus.alu_data;
    bus.clkb = 1'b0;
    bus.nweb = 1'b1;
    bus.ab = fa_q[head_q];
    bus.db = fd_q[head_q];
    if (!reset) begin
      if (bus.alu_we) begin
        bus.clka = 1'b1;
        bus.nwea = 1'b0;
        pop = cnt_q != 3'd0;
      end else if (full) begin
        pop = 1'b1;
      end else if (bus.rd_req && !hazard) begin
        gnt = 1'b1;
        bus.clka = 1'b1;
        bus.clkb = 1'b1;
        bus.aa = bus.rd_src1;
        bus.ab = bus.rd_src2;
      end else begin
        pop = cnt_q != 3'd0;
      end
    end
    if (pop) begin
      bus.clkb = 1'b1;
      bus.nweb = 1'b0;
    end
    fa_d = fa_q;
    fd_d = fd_q;
    v_d = v_q;
    if (pop) v_d[head_q] = 1'b0;
    if (push) begin
      fa_d[tail_q] = bus.ld_addr;
      fd_d[tail_q] = bus.ld_data;
      v_d[tail_q] = 1'b1;
    end
    head_d = head_q + 2'(pop);
    tail_d = tail_q + 2'(push);
    cnt_d = cnt_q + 3'(push) - 3'(pop);
    full_d = cnt_d == 3'd4;
    valid_d = gnt;
    d1_d = valid_q ? bus.qa : d1_q;
    d2_d = valid_q ? bus.qb : d2_q;
`ifdef REG_WB_SEQ_OVF_EN
    ovf_d = ovf_q || (bus.ld_we && full);
`else
    ovf_d = 1'b0;
`endif
    bus.rd_gnt = gnt;
    bus.rd_valid = valid_q && !reset;
    bus.rd_d1 = reset ? '0 : d1_d;
    bus.rd_d2 = reset ? '0 : d2_d;
    bus.ld_full = full_q;
    bus.ld_ovf = ovf_q && !reset;
  end
  always_ff @(posedge sys_clk) begin
    fa_q <= fa_d;
    fd_q <= fd_d;
    if (reset) begin
      v_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q <= '0;
      valid_q <= 1'b0;
      full_q <= 1'b0;
      ovf_q <= 1'b0;
      d1_q <= '0;
      d2_q <= '0;
    end else begin
      v_q <= v_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q <= cnt_d;
      valid_q <= valid_d;
      full_q <= full_d;
      ovf_q <= ovf_d;
      d1_q <= d1_d;
      d2_q <= d2_d;
    end
  end
endmodule

// File: tb/tb_reg_wb_seq.sv
// tb_reg_wb_seq: vector table plus hand sequences against a behavioural dual-port register RAM
module tb_reg_wb_seq;
`ifdef REG_WB_SEQ_OVF_EN
  localparam logic OVF = 1'b1;
`else
  localparam logic OVF = 1'b0;
`endif
  localparam logic [3:0] IDLE = 4'b0101, RD = 4'b1111, AW = 4'b1001, PP = 4'b0110, AP = 4'b1010;
  localparam int N = 29;
  typedef struct {
    logic rst, rq; logic [5:0] s1, s2;
    logic aw; logic [5:0] aad; logic [31:0] adt;
    logic lw; logic [5:0] lad; logic [31:0] ldt;
    logic gnt, v; logic [31:0] d1, d2; logic full, ovf; logic [3:0] prt;
  } vec_t;
  logic sys_clk = 1'b0;
  logic reset, init;
  logic [31:0] mem [64];
  int total = 0, bad = 0, n;
  vec_t t [N];
  reg_wb_seq_if bus();
  reg_wb_seq dut (.sys_clk(sys_clk), .reset(reset), .bus(bus));
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) begin
    if (init) begin
      for (int i = 0; i < 64; i++)
        mem[i] <= (i == 5) ? 32'h11111111 : (i == 9) ? 32'h22222222 : 32'h5A000000 | 32'(i);
    end else begin
      if (bus.clka) begin
        if (!bus.nwea) mem[bus.aa] <= bus.da;
        bus.qa <= mem[bus.aa];
      end
      if (bus.clkb) begin
        if (!bus.nweb) mem[bus.ab] <= bus.db;
        bus.qb <= mem[bus.ab];
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic drive(input vec_t x);
    reset = x.rst;
    bus.rd_req = x.rq;
    bus.rd_src1 = x.s1;
    bus.rd_src2 = x.s2;
    bus.alu_we = x.aw;
    bus.alu_addr = x.aad;
    bus.alu_data = x.adt;
    bus.ld_we = x.lw;
    bus.ld_addr = x.lad;
    bus.ld_data = x.ldt;
  endtask
  task automatic req(input logic rq, input logic [5:0] s1, input logic [5:0] s2,
                     input logic lw, input logic [5:0] la, input logic [31:0] ld);
    reset = 1'b0;
    bus.alu_we = 1'b0;
    bus.rd_req = rq;
    bus.rd_src1 = s1;
    bus.rd_src2 = s2;
    bus.ld_we = lw;
    bus.ld_addr = la;
    bus.ld_data = ld;
  endtask
  function automatic logic [3:0] ports();
    return {bus.clka, bus.nwea, bus.clkb, bus.nweb};
  endfunction
  initial begin
    t[0]  = '{1,1,5,9,0,0,0,0,0,0, 0,0,0,0,0,0,IDLE};
    t[1]  = '{0,1,5,9,0,0,0,0,0,0, 1,0,0,0,0,0,RD};
    t[2]  = '{0,0,0,0,0,0,0,0,0,0, 0,1,'h11111111,'h22222222,0,0,IDLE};
    t[3]  = '{0,0,0,0,0,0,0,0,0,0, 0,0,'h11111111,'h22222222,0,0,IDLE};
    t[4]  = '{0,1,3,5,1,3,'hDEADBEEF,0,0,0, 0,0,'h11111111,'h22222222,0,0,AW};
    t[5]  = '{0,1,3,5,0,0,0,0,0,0, 1,0,'h11111111,'h22222222,0,0,RD};
    t[6]  = '{0,0,0,0,0,0,0,0,0,0, 0,1,'hDEADBEEF,'h11111111,0,0,IDLE};
    t[7]  = '{0,1,7,9,0,0,0,1,7,'hCAFE0007, 0,0,'hDEADBEEF,'h11111111,0,0,IDLE};
    t[8]  = '{0,1,7,9,0,0,0,0,0,0, 0,0,'hDEADBEEF,'h11111111,0,0,PP};
    t[9]  = '{0,1,7,9,0,0,0,0,0,0, 1,0,'hDEADBEEF,'h11111111,0,0,RD};
    t[10] = '{0,0,0,0,0,0,0,0,0,0, 0,1,'hCAFE0007,'h22222222,0,0,IDLE};
    t[11] = '{0,1,1,2,0,0,0,1,20,'hA0000020, 1,0,'hCAFE0007,'h22222222,0,0,RD};
    t[12] = '{0,1,1,2,0,0,0,1,21,'hA0000021, 1,1,'h5A000001,'h5A000002,0,0,RD};
    t[13] = '{0,1,1,2,0,0,0,1,22,'hA0000022, 1,1,'h5A000001,'h5A000002,0,0,RD};
    t[14] = '{0,1,1,2,0,0,0,1,23,'hA0000023, 1,1,'h5A000001,'h5A000002,0,0,RD};
    t[15] = '{0,1,1,2,0,0,0,1,24,'hA0000024, 0,1,'h5A000001,'h5A000002,1,0,PP};
    t[16] = '{0,0,0,0,0,0,0,0,0,0, 0,0,'h5A000001,'h5A000002,0,1,PP};
    t[17] = '{0,1,1,2,0,0,0,1,25,'hA0000025, 1,0,'h5A000001,'h5A000002,0,1,RD};
    t[18] = '{1,1,1,2,1,30,'hE0000030,1,26,'hA0000026, 0,0,0,0,0,0,IDLE};
    t[19] = '{0,1,22,23,0,0,0,0,0,0, 1,0,0,0,0,0,RD};
    t[20] = '{0,1,20,21,0,0,0,0,0,0, 1,1,'h5A000016,'h5A000017,0,0,RD};
    t[21] = '{0,0,0,0,0,0,0,0,0,0, 0,1,'hA0000020,'hA0000021,0,0,IDLE};
    t[22] = '{0,0,0,0,1,41,'hC0000041,1,40,'hB0000040, 0,0,'hA0000020,'hA0000021,0,0,AW};
    t[23] = '{0,0,0,0,1,42,'hC0000042,0,0,0, 0,0,'hA0000020,'hA0000021,0,0,AP};
    t[24] = '{0,1,40,41,0,0,0,0,0,0, 1,0,'hA0000020,'hA0000021,0,0,RD};
    t[25] = '{0,1,42,9,0,0,0,0,0,0, 1,1,'hB0000040,'hC0000041,0,0,RD};
    t[26] = '{0,1,24,30,0,0,0,0,0,0, 1,1,'hC0000042,'h22222222,0,0,RD};
    t[27] = '{0,1,26,25,0,0,0,0,0,0, 1,1,'h5A000018,'h5A00001E,0,0,RD};
    t[28] = '{0,0,0,0,0,0,0,0,0,0, 0,1,'h5A00001A,'h5A000019,0,0,IDLE};
    init = 1'b1;
    drive(t[0]);
    @(negedge sys_clk);
    init = 1'b0;
    for (int r = 0; r < N; r++) begin
      drive(t[r]);
      #1;
      chk($sformatf("r%0d rd_gnt", r), 32'(bus.rd_gnt), 32'(t[r].gnt));
      chk($sformatf("r%0d rd_valid", r), 32'(bus.rd_valid), 32'(t[r].v));
      chk($sformatf("r%0d rd_d1", r), bus.rd_d1, t[r].d1);
      chk($sformatf("r%0d rd_d2", r), bus.rd_d2, t[r].d2);
      chk($sformatf("r%0d ld_full", r), 32'(bus.ld_full), 32'(t[r].full));
      chk($sformatf("r%0d ld_ovf", r), 32'(bus.ld_ovf), 32'(t[r].ovf & OVF));
      chk($sformatf("r%0d ports", r), 32'(ports()), 32'(t[r].prt));
      @(negedge sys_clk);
    end
    // push/pop overlap keeps count; a read proceeds once only non-matching entries remain
    req(1, 50, 51, 1, 50, 32'hD0000050);
    #1; chk("seqA gnt", 32'(bus.rd_gnt), 0); chk("seqA ports", 32'(ports()), 32'(IDLE));
    @(negedge sys_clk);
    req(1, 50, 51, 1, 51, 32'hD0000051);
    #1; chk("seqB gnt", 32'(bus.rd_gnt), 0); chk("seqB ports", 32'(ports()), 32'(PP));
    @(negedge sys_clk);
    req(1, 50, 51, 1, 52, 32'hD0000052);
    #1; chk("seqC gnt", 32'(bus.rd_gnt), 0); chk("seqC ports", 32'(ports()), 32'(PP));
    @(negedge sys_clk);
    req(1, 50, 51, 0, 0, 0);
    #1; chk("seqD gnt", 32'(bus.rd_gnt), 1); chk("seqD ports", 32'(ports()), 32'(RD));
    @(negedge sys_clk);
    req(1, 52, 9, 0, 0, 0);
    #1;
    chk("seqE gnt", 32'(bus.rd_gnt), 0);
    chk("seqE ports", 32'(ports()), 32'(PP));
    chk("seqE valid", 32'(bus.rd_valid), 1);
    chk("seqE d1", bus.rd_d1, 32'hD0000050);
    chk("seqE d2", bus.rd_d2, 32'hD0000051);
    @(negedge sys_clk);
    n = 0;
    while (n < 5) begin
      req(1, 52, 9, 0, 0, 0);
      #1;
      if (bus.rd_gnt) break;
      @(negedge sys_clk);
      n++;
    end
    chk("seqF grant wait", 32'(n), 0);
    @(negedge sys_clk);
    req(0, 0, 0, 0, 0, 0);
    #1;
    chk("seqG valid", 32'(bus.rd_valid), 1);
    chk("seqG d1", bus.rd_d1, 32'hD0000052);
    chk("seqG d2", bus.rd_d2, 32'h22222222);
    @(negedge sys_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
